// File: rtl/attitude_pd_ctrl_pkg.sv
// Shared constants, types and saturation helpers for the attitude PD controller.
// Optional build macro: SPD_SLEW_EN (slew-limited motor outputs).
package attitude_ctrl_pkg;

    localparam logic [10:0] MIN_RUN_SPEED = 11'd200;
    localparam logic [10:0] CAL_SPEED     = 11'd656;

    localparam int ERR_MAX   = 511;
    localparam int ERR_MIN   = -512;
    localparam int DDIFF_MAX = 63;
    localparam int DDIFF_MIN = -64;
    localparam int SPD_MAX   = 2047;

    typedef logic signed [9:0]  err_t;
    typedef logic signed [9:0]  pterm_t;
    typedef logic signed [11:0] dterm_t;
    typedef logic signed [6:0]  ddiff_t;
    typedef logic signed [12:0] mix_t;
    typedef logic [10:0]        spd_t;

    function automatic err_t sat_err(input logic signed [16:0] e);
        if (e > ERR_MAX) return err_t'(ERR_MAX);
        if (e < ERR_MIN) return err_t'(ERR_MIN);
        return err_t'(e);
    endfunction

    function automatic ddiff_t sat_ddiff(input logic signed [10:0] d);
        if (d > DDIFF_MAX) return ddiff_t'(DDIFF_MAX);
        if (d < DDIFF_MIN) return ddiff_t'(DDIFF_MIN);
        return ddiff_t'(d);
    endfunction

    function automatic spd_t clip_spd(input mix_t v);
        if (v < 0) return '0;
        if (v > SPD_MAX) return spd_t'(SPD_MAX);
        return spd_t'(v);
    endfunction

endpackage

// File: rtl/attitude_pd_ctrl_if.sv
// Attitude sample in / motor speed out bundle between the inertial side
// (master) and the PD controller (slave).
interface attitude_pd_ctrl_if;

    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] roll;
    logic signed [15:0] yaw;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic [8:0]         thrst;
    logic               inertial_cal;
    logic [10:0]        frnt_spd;
    logic [10:0]        bck_spd;
    logic [10:0]        lft_spd;
    logic [10:0]        rght_spd;
    logic               spd_vld;

    modport master (
        output vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
        output thrst, inertial_cal,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
        input  thrst, inertial_cal,
        output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
    );

endinterface

// File: rtl/attitude_pd_ctrl_pd_axis.sv
// One attitude axis: error saturation, error history queue, fill counter
// and registered P / D terms (two pipeline stages).
module pd_axis
    import attitude_ctrl_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int COEFF = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cal,
    input  logic               i_vld,
    input  logic signed [15:0] i_act,
    input  logic signed [15:0] i_des,
    output pterm_t             o_p,
    output dterm_t             o_d,
    output logic               o_vld
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    logic signed [16:0] w_err;
    err_t               w_err_sat;
    logic signed [12:0] w_err_ext;
    logic signed [10:0] w_ddiff;
    ddiff_t             w_dsat;
    pterm_t             w_p;
    dterm_t             w_d;

    err_t               r_err;
    logic               r_vld1;
    err_t               r_q [DEPTH];
    logic [FW-1:0]      r_fill;
    pterm_t             r_p;
    dterm_t             r_d;
    logic               r_vld2;

    assign w_err     = $signed({i_act[15], i_act}) - $signed({i_des[15], i_des});
    assign w_err_sat = sat_err(w_err);
    assign w_err_ext = $signed({{3{r_err[9]}}, r_err});
    assign w_p       = pterm_t'((w_err_ext * 13'sd5) >>> 3);
    assign w_ddiff   = $signed({r_err[9], r_err})
                     - $signed({r_q[DEPTH-1][9], r_q[DEPTH-1]});
    assign w_dsat    = sat_ddiff(w_ddiff);
    // Derivative is meaningless until the queue holds a full history
    assign w_d       = (r_fill < FILL_FULL) ? '0 :
                       dterm_t'($signed({{5{w_dsat[6]}}, w_dsat})
                                * $signed(12'(COEFF)));

    // Stage 1: capture saturated error of an accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= '0;
            r_vld1 <= 1'b0;
        end else if (i_cal) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= i_vld;
            if (i_vld) r_err <= w_err_sat;
        end
    end

    // Stage 2: P/D terms, history push and fill tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_fill <= '0;
            r_p    <= '0;
            r_d    <= '0;
            r_vld2 <= 1'b0;
        end else if (i_cal) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
            r_fill <= '0;
            r_vld2 <= 1'b0;
        end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_p    <= w_p;
                r_d    <= w_d;
                r_q[0] <= r_err;
                for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
                if (r_fill < FILL_FULL) r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign o_p   = r_p;
    assign o_d   = r_d;
    assign o_vld = r_vld2;

endmodule

// File: rtl/attitude_pd_ctrl.sv
// Three-axis PD attitude controller: mixes P/D corrections with throttle
// into four clipped motor speeds. Optional macro SPD_SLEW_EN limits each
// update to +/- SLEW_MAX.
module attitude_pd_ctrl
    import attitude_ctrl_pkg::*;
#(
    parameter int D_QUEUE_DEPTH = 12,
    parameter int D_COEFF       = 6
`ifdef SPD_SLEW_EN
    ,
    parameter int SLEW_MAX      = 64
`endif
) (
    input logic               clk,
    input logic               rst_n,
    attitude_pd_ctrl_if.slave bus
);

    logic signed [15:0] w_act [3];
    logic signed [15:0] w_des [3];
    pterm_t             w_p [3];
    dterm_t             w_d [3];
    logic [2:0]         w_av;
    mix_t               w_pd [3];
    mix_t               w_base;
    spd_t               w_tgt [4];
    spd_t               w_nxt [4];
    logic               w_stg_vld;

    logic [8:0]         r_thr1;
    logic [8:0]         r_thr2;
    spd_t               r_spd [4];
    logic               r_spd_vld;

    assign w_act[0] = bus.ptch;
    assign w_act[1] = bus.roll;
    assign w_act[2] = bus.yaw;
    assign w_des[0] = bus.d_ptch;
    assign w_des[1] = bus.d_roll;
    assign w_des[2] = bus.d_yaw;

    for (genvar i = 0; i < 3; i++) begin : g_ax
        pd_axis #(
            .DEPTH (D_QUEUE_DEPTH),
            .COEFF (D_COEFF)
        ) u_ax (
            .clk   (clk),
            .rst_n (rst_n),
            .i_cal (bus.inertial_cal),
            .i_vld (bus.vld),
            .i_act (w_act[i]),
            .i_des (w_des[i]),
            .o_p   (w_p[i]),
            .o_d   (w_d[i]),
            .o_vld (w_av[i])
        );
    end

    // All three axes advance in lockstep
    assign w_stg_vld = &w_av;

    // Throttle follows the sample through stages 1 and 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr1 <= '0;
            r_thr2 <= '0;
        end else begin
            if (bus.vld && !bus.inertial_cal) r_thr1 <= bus.thrst;
            r_thr2 <= r_thr1;
        end
    end

    // Motor mixer with clipping to the 11-bit speed range
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_pd[i] = $signed({{3{w_p[i][9]}}, w_p[i]})
                    + $signed({w_d[i][11], w_d[i]});
        end
        w_base   = $signed({2'b00, MIN_RUN_SPEED})
                 + $signed({4'b0000, r_thr2});
        w_tgt[0] = clip_spd(w_base - w_pd[0] - w_pd[2]);
        w_tgt[1] = clip_spd(w_base + w_pd[0] - w_pd[2]);
        w_tgt[2] = clip_spd(w_base - w_pd[1] + w_pd[2]);
        w_tgt[3] = clip_spd(w_base + w_pd[1] + w_pd[2]);
    end

`ifdef SPD_SLEW_EN
    logic r_first;

    function automatic spd_t slew_lim(input spd_t prev, input spd_t tgt);
        logic [11:0] hi;
        hi = {1'b0, prev} + 12'(SLEW_MAX);
        if ({1'b0, tgt} > hi) return spd_t'(hi);
        if ({1'b0, tgt} + 12'(SLEW_MAX) < {1'b0, prev})
            return prev - spd_t'(SLEW_MAX);
        return tgt;
    endfunction

    // Rate-limit against the last output, except on the first update
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_nxt[i] = r_first ? w_tgt[i] : slew_lim(r_spd[i], w_tgt[i]);
        end
    end

    // First-update flag re-arms on reset and calibration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_first <= 1'b1;
        else if (bus.inertial_cal) r_first <= 1'b1;
        else if (w_stg_vld)        r_first <= 1'b0;
    end
`else
    // Clipped targets go straight to the output registers
    always_comb begin
        for (int i = 0; i < 4; i++) w_nxt[i] = w_tgt[i];
    end
`endif

    // Stage 3: output registers with calibration override
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_spd[i] <= '0;
            r_spd_vld <= 1'b0;
        end else if (bus.inertial_cal) begin
            for (int i = 0; i < 4; i++) r_spd[i] <= CAL_SPEED;
            r_spd_vld <= 1'b0;
        end else begin
            r_spd_vld <= w_stg_vld;
            if (w_stg_vld) begin
                for (int i = 0; i < 4; i++) r_spd[i] <= w_nxt[i];
            end
        end
    end

    assign bus.frnt_spd = r_spd[0];
    assign bus.bck_spd  = r_spd[1];
    assign bus.lft_spd  = r_spd[2];
    assign bus.rght_spd = r_spd[3];
    assign bus.spd_vld  = r_spd_vld;

endmodule
